// File: rtl/demux_b.sv
// Clocked 1-to-2 demultiplexer: each input word is steered by sel into one of
// two independent 2-entry buffered channels with valid/ready outputs and delivered-word counters.

// Handshake (all ports): a beat transfers on a rising edge where valid && ready
// are both high; a producer holds data stable while valid && !ready.
module demux_b_chan #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_ready_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CNT_W-1:0] cnt_o
);
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e             state_q, state_d;
  logic             wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [2];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop;

  assign valid_o = (state_q != EMPTY);
  assign full_o  = (state_q == FULL);
  assign pop     = valid_o && pop_ready_i;
  assign dout_o  = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;

  // Push and pop together leave occupancy unchanged; push is never offered when FULL.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (push_i && !pop) begin
      if (state_q == EMPTY) state_d = ONE;
      else                  state_d = FULL;
    end else if (pop && !push_i) begin
      if (state_q == FULL) state_d = ONE;
      else                 state_d = EMPTY;
    end
    if (pop) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end
endmodule

module demux_b #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);
  logic full1, full2;
  logic accept, push1, push2;

  // in_ready looks only at the selected channel's occupancy, never at the
  // consumer's ready, so a full channel cannot take a word in the cycle it drains.
  assign in_ready = !rst && (sel ? !full2 : !full1);
  assign accept   = in_valid && in_ready;
  assign push1    = accept && !sel;
  assign push2    = accept && sel;

  demux_b_chan #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ch1 (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push1),
    .din_i      (din),
    .pop_ready_i(out1_ready),
    .dout_o     (out1),
    .valid_o    (out1_valid),
    .full_o     (full1),
    .cnt_o      (cnt1)
  );

  demux_b_chan #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ch2 (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push2),
    .din_i      (din),
    .pop_ready_i(out2_ready),
    .dout_o     (out2),
    .valid_o    (out2_valid),
    .full_o     (full2),
    .cnt_o      (cnt2)
  );
endmodule

// File: tb/tb_demux_b.sv
// Directed bench for demux_b: reset, routing, backpressure, channel independence,
// push+pop at one entry, counter wrap and mid-stream reset.
module tb_demux_b;
  logic        clk;
  logic        rst;
  logic        sel;
  logic [15:0] din;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out1, out2;
  logic        out1_valid, out2_valid;
  logic        out1_ready, out2_ready;
  logic [7:0]  cnt1, cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  demux_b #(.WIDTH(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .din       (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out1      (out1),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .out2      (out2),
    .out2_valid(out2_valid),
    .out2_ready(out2_ready),
    .cnt1      (cnt1),
    .cnt2      (cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; din = 16'h0005; in_valid = 1'b1;
    out1_ready = 1'b0; out2_ready = 1'b0;

    // Reset held two cycles with in_valid high
    tick(); tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_v1", {31'd0, out1_valid}, 32'd0);
    check("rst_v2", {31'd0, out2_valid}, 32'd0);
    check("rst_out1", {16'd0, out1}, 32'd0);
    check("rst_out2", {16'd0, out2}, 32'd0);
    check("rst_cnt1", {24'd0, cnt1}, 32'd0);
    check("rst_cnt2", {24'd0, cnt2}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic routing
    out1_ready = 1'b1; out2_ready = 1'b1;
    sel = 1'b0; din = 16'h0001; in_valid = 1'b1;
    tick();
    check("rt_v1", {31'd0, out1_valid}, 32'd1);
    check("rt_out1", {16'd0, out1}, 32'h0001);
    sel = 1'b1; din = 16'h0010;
    tick();
    check("rt_v2", {31'd0, out2_valid}, 32'd1);
    check("rt_out2", {16'd0, out2}, 32'h0010);
    check("rt_cnt1", {24'd0, cnt1}, 32'd1);
    check("rt_v1_drained", {31'd0, out1_valid}, 32'd0);
    in_valid = 1'b0;
    tick();
    check("rt_cnt2", {24'd0, cnt2}, 32'd1);
    check("rt_v2_drained", {31'd0, out2_valid}, 32'd0);

    // Backpressure on channel 1
    out1_ready = 1'b0; sel = 1'b0; in_valid = 1'b1; din = 16'h0010;
    tick();
    din = 16'h0011;
    #1;
    check("bp_rdy_one", {31'd0, in_ready}, 32'd1);
    tick();
    din = 16'h0012;
    #1;
    check("bp_rdy_full", {31'd0, in_ready}, 32'd0);
    check("bp_head0", {16'd0, out1}, 32'h0010);
    tick();
    check("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
    check("bp_hold_head", {16'd0, out1}, 32'h0010);
    out1_ready = 1'b1;
    #1;
    check("bp_no_bypass", {31'd0, in_ready}, 32'd0);
    tick();
    check("bp_head1", {16'd0, out1}, 32'h0011);
    check("bp_rdy_again", {31'd0, in_ready}, 32'd1);
    check("bp_cnt1_a", {24'd0, cnt1}, 32'd2);
    tick();
    check("bp_head2", {16'd0, out1}, 32'h0012);
    check("bp_cnt1_b", {24'd0, cnt1}, 32'd3);
    in_valid = 1'b0;
    tick();
    check("bp_cnt1_c", {24'd0, cnt1}, 32'd4);
    check("bp_v1_empty", {31'd0, out1_valid}, 32'd0);

    // Channel independence: fill channel 2, then route to channel 1
    out2_ready = 1'b0; out1_ready = 1'b0; sel = 1'b1; in_valid = 1'b1;
    din = 16'hA000;
    tick();
    din = 16'hA001;
    tick();
    #1;
    check("ind_ch2_full", {31'd0, in_ready}, 32'd0);
    sel = 1'b0; din = 16'hABCD;
    #1;
    check("ind_rdy_sel0", {31'd0, in_ready}, 32'd1);
    tick();
    check("ind_out1", {16'd0, out1}, 32'h0000ABCD);
    check("ind_v1", {31'd0, out1_valid}, 32'd1);
    check("ind_out2", {16'd0, out2}, 32'h0000A000);
    check("ind_cnt2", {24'd0, cnt2}, 32'd1);
    in_valid = 1'b0; out1_ready = 1'b1;
    tick();
    check("ind_cnt1", {24'd0, cnt1}, 32'd5);

    // Push+pop while channel 1 holds one word
    out1_ready = 1'b0; sel = 1'b0; din = 16'h1111; in_valid = 1'b1;
    tick();
    check("pp_head_1111", {16'd0, out1}, 32'h1111);
    out1_ready = 1'b1; din = 16'h2222;
    tick();
    check("pp_head_2222", {16'd0, out1}, 32'h2222);
    check("pp_v1", {31'd0, out1_valid}, 32'd1);
    check("pp_occ", {30'd0, dut.u_ch1.state_q}, 32'd1);
    check("pp_cnt1", {24'd0, cnt1}, 32'd6);
    in_valid = 1'b0;
    tick();
    check("pp_cnt1_drain", {24'd0, cnt1}, 32'd7);

    // Counter wrap on channel 2: drain the two buffered words, then stream
    out2_ready = 1'b1;
    tick(); tick();
    check("wr_cnt2_3", {24'd0, cnt2}, 32'd3);
    sel = 1'b1; in_valid = 1'b1;
    for (int j = 0; j < 253; j++) begin
      din = 16'h5000 + 16'(j);
      tick();
      if (j % 50 == 0) check("wr_stream_head", {16'd0, out2}, 32'h5000 + j);
    end
    check("wr_cnt2_ff", {24'd0, cnt2}, 32'hFF);
    in_valid = 1'b0;
    tick();
    check("wr_cnt2_wrap", {24'd0, cnt2}, 32'd0);
    check("wr_v2_empty", {31'd0, out2_valid}, 32'd0);

    // Reset mid-stream discards buffered words
    out1_ready = 1'b0; sel = 1'b0; in_valid = 1'b1; din = 16'hBEEF;
    tick();
    din = 16'hCAFE;
    tick();
    check("mr_v1_before", {31'd0, out1_valid}, 32'd1);
    in_valid = 1'b0; out1_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mr_v1_after", {31'd0, out1_valid}, 32'd0);
    check("mr_out1", {16'd0, out1}, 32'd0);
    check("mr_cnt1", {24'd0, cnt1}, 32'd0);
    din = 16'h3333; in_valid = 1'b1;
    tick();
    check("mr_new_word", {16'd0, out1}, 32'h3333);
    in_valid = 1'b0;
    tick();
    check("mr_cnt1_new", {24'd0, cnt1}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/demux_b.md
# demux_b

Clocked 1-to-2 demultiplexer for the 16-bit datapath: takes one 16-bit word stream and steers each word to one of two destination channels chosen by `sel`. It is the inverse of the B-bus source multiplexer. It sits after the ALU/bus-B stage and feeds the two write-back destinations. Each destination has a 2-entry buffer with valid/ready handshakes, so a stalled destination never drops data and never blocks the other channel. Per-channel delivered-word counters support debug.

## Interface
- `WIDTH`, 16, data width of `din`, `out1`, `out2`
- `CNT_W`, 8, width of the delivered-word counters
- `clk`  input  1  rising-edge clock; all state updates on it
- `rst`  input  1  synchronous, active-high reset
- `sel`  input  1  destination select: 0 routes to channel 1, 1 routes to channel 2; sampled only on an accepted beat
- `din`  input  WIDTH  input word
- `in_valid`  input  1  `din`/`sel` valid this cycle
- `in_ready`  output  1  block accepts the beat this cycle
- `out1`  output  WIDTH  channel-1 head word
- `out1_valid`  output  1  channel-1 buffer non-empty
- `out1_ready`  input  1  channel-1 consumer takes head word
- `out2`  output  WIDTH  channel-2 head word
- `out2_valid`  output  1  channel-2 buffer non-empty
- `out2_ready`  input  1  channel-2 consumer takes head word
- `cnt1`  output  CNT_W  words delivered on channel 1, wrapping
- `cnt2`  output  CNT_W  words delivered on channel 2, wrapping

## Operation
- Each channel has a 2-entry FIFO: storage regs, 1-bit write/read pointers, 2-bit occupancy (0..2).
- Per-channel occupancy states:
  - EMPTY (0)
  - ONE (1)
  - FULL (2)
  - The channel moves up on push-only, down on pop-only, and holds on push+pop or idle.
- `in_ready` = !rst && (sel ? occ2 != 2 : occ1 != 2).
  - Combinational on `sel` and occupancy only.
  - Does not depend on same-cycle `outN_ready`, so there is no full-bypass.
- Accept (push) = `in_valid && in_ready`. The word is written to the selected channel's tail. The unselected channel is untouched.
- Pop on channel N = `outN_valid && outN_ready`. The read pointer advances and `cntN` increments.
- `outN_valid` = occN != 0. `outN` = storage[rd_ptrN], driven from registers with no combinational path from `din`.
- Simultaneous push and pop on the same channel:
  - At ONE: occupancy stays 1, the head becomes the new word next cycle.
  - At FULL: push is impossible because `in_ready` = 0; pop alone → ONE.
- Channels are independent: a stalled channel 2 (FULL) does not affect acceptance for `sel`=0.
- Counters wrap from 2^CNT_W−1 to 0 with no saturation or flag.
- `in_valid` low: `sel`/`din` are ignored and no state changes from the input side.

## Timing
- Reset (`rst` high at a clock edge) sets:
  - occupancy 0 and pointers 0 on both channels
  - all storage 0, so `out1` = `out2` = 0
  - `out1_valid` = `out2_valid` = 0
  - `cnt1` = `cnt2` = 0
  - `in_ready` = 0 while `rst` is high
- Reset mid-operation discards buffered words. Pops presented in the reset cycle are not counted.
- Latency: a word accepted at edge k appears on `outN` with `outN_valid` = 1 after edge k when the channel was EMPTY. Otherwise it appears after the earlier words are popped.
- Throughput: one word per cycle per channel sustained when the consumer holds `outN_ready` = 1. Alternating `sel` gives one word per cycle aggregate.
- Order is preserved within each channel. There is no ordering guarantee across channels.
- `in_ready` is valid in the same cycle as `sel`. A producer may change `sel` every cycle.

## Test plan
- Reset:
  - Stimulus: assert `rst` 2 cycles with `in_valid` = 1.
  - Required: `in_ready` = 0, both valids 0, `out1` = `out2` = 0, counters 0.
  - Then deassert `rst`: `in_ready` = 1.
- Basic routing:
  - Stimulus: `sel`=0, `din`=16'h0001, then `sel`=1, `din`=16'h0010, with both readies 1.
  - Required: `out1` = 0001 is valid one cycle after its accept, then `out2` = 0010. `cnt1` = `cnt2` = 1.
- Backpressure/full:
  - Stimulus: `out1_ready` = 0; push 16'h0010, 16'h0011, 16'h0012 with `sel` = 0.
  - Required: `in_ready` drops after two accepts, with 0012 held off. Raising `out1_ready` delivers 0010 then 0011 in order, then 0012 is accepted.
- Channel independence:
  - Stimulus: channel 2 FULL with `out2_ready` = 0; push 16'hABCD with `sel` = 0.
  - Required: accepted immediately and delivered on `out1`. `out2` is unchanged and `cnt2` is unchanged.
- Push+pop at ONE:
  - Stimulus: channel 1 holds 16'h1111 with `out1_ready` = 1; push 16'h2222 the same cycle.
  - Required: next cycle `out1` = 2222, occupancy 1, `cnt1` +1.
- Wrap and reset mid-stream:
  - Stimulus: deliver 256 words on channel 2.
  - Required: `cnt2` returns to 0.
  - Stimulus: then buffer 2 words on channel 1 and pulse `rst`.
  - Required: `out1_valid` = 0 and the words are lost.
